// File: rtl/if_fetch.sv
// if_fetch: instruction fetch stage assembling 32-bit words from a byte-wide memory port,
// fronted by a direct-mapped one-word-per-line instruction cache.
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0,
  parameter int          IDX_W    = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        branch_taken_i,
  input  logic [31:0] branch_target_i,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_ack_i,
  input  logic [7:0]  mem_rdata_i,
  output logic        inst_valid_o,
  output logic [31:0] pc_o,
  output logic [31:0] inst_o
);
  localparam int N  = 1 << IDX_W;
  localparam int TW = 30 - IDX_W;
  typedef enum logic [1:0] {LOOKUP, FETCH, READY} state_t;
  state_t state, state_d;
  logic [31:0] pc, addr_q;
  logic [1:0] cnt;
  logic [23:0] part;
  logic [N-1:0] vld;
  logic [TW-1:0] tags [N];
  logic [31:0] data [N];
  logic valid_q;
  logic [IDX_W-1:0] idx;
  logic [TW-1:0] tag;
  logic hit, fill;
  logic [31:0] word;
  assign idx = pc[IDX_W+1:2];
  assign tag = pc[31:IDX_W+2];
  assign hit = vld[idx] && tags[idx] == tag;
  assign fill = state == FETCH && mem_ack_i && cnt == 2'd3 && !branch_taken_i;
  // earlier bytes shift down so the 4th byte lands in [31:24] little-endian
  assign word = {mem_rdata_i, part};
  assign mem_req_o = state == FETCH;
  assign mem_addr_o = mem_req_o ? pc + 32'(cnt) : addr_q;
  assign inst_valid_o = valid_q & ~branch_taken_i;
  always_comb begin
    state_d = branch_taken_i ? LOOKUP :
              state == LOOKUP ? (hit ? READY : FETCH) :
              state == FETCH ? (mem_ack_i && cnt == 2'd3 ? READY : FETCH) :
              stall_i ? READY : LOOKUP;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= LOOKUP;
    else state <= state_d;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc <= RESET_PC;
      addr_q <= '0;
      cnt <= '0;
      part <= '0;
      vld <= '0;
      valid_q <= 1'b0;
      pc_o <= '0;
      inst_o <= '0;
    end else begin
      if (mem_req_o) addr_q <= mem_addr_o;
      if (branch_taken_i) begin
        pc <= branch_target_i;
        cnt <= '0;
        valid_q <= 1'b0;
      end else if (state == LOOKUP) begin
        cnt <= '0;
        if (hit) begin
          pc_o <= pc;
          inst_o <= data[idx];
          valid_q <= 1'b1;
        end
      end else if (state == FETCH) begin
        if (mem_ack_i) begin
          cnt <= cnt + 2'd1;
          part <= {mem_rdata_i, part[23:8]};
        end
        if (fill) begin
          vld[idx] <= 1'b1;
          pc_o <= pc;
          inst_o <= word;
          valid_q <= 1'b1;
        end
      end else if (!stall_i) begin
        pc <= pc + 32'd4;
        valid_q <= 1'b0;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (fill) begin
      tags[idx] <= tag;
      data[idx] <= word;
    end
  end
endmodule

// File: doc/if_fetch.md
Name: if_fetch

Overview:
- Instruction-fetch stage. It produces the pc/instruction pair that the decode stage consumes through IF_ID.
- Fetches 32-bit instructions over the byte-wide memory-controller port and assembles them little-endian.
- Holds a small direct-mapped instruction cache so repeated instructions return in one cycle.
- Obeys the pipeline stall from decode/downstream and the branch redirect from execute.

Parameters:
RESET_PC, 32'h0, pc loaded on reset
IDX_W, 5, cache index width (2^IDX_W one-word entries)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-low
stall_i  in  1  downstream not accepting (decode stall or later)
branch_taken_i  in  1  redirect pulse from execute
branch_target_i  in  32  redirect pc
mem_req_o  out  1  byte read request
mem_addr_o  out  32  byte address
mem_ack_i  in  1  byte returned this cycle
mem_rdata_i  in  8  returned byte, valid with mem_ack_i
inst_valid_o  out  1  pc_o/inst_o valid
pc_o  out  32  instruction address
inst_o  out  32  instruction word

Behaviour:
- Reset (rst low, async):
  - pc=RESET_PC, state=LOOKUP, byte counter=0.
  - All cache valid bits cleared.
  - mem_req_o=0, mem_addr_o=0, inst_valid_o=0, pc_o=0, inst_o=0.
- Reset mid-fetch: abandon the fetch silently; resume at RESET_PC after release.
- Cache: index=pc[IDX_W+1:2], tag=pc[31:IDX_W+2]. Hit = valid & tag match.
- States:
  - LOOKUP (1 cycle):
    - Hit: latch pc/word into output regs, go READY (inst_valid_o high next cycle).
    - Miss: go FETCH with cnt=0.
  - FETCH:
    - mem_req_o=1, mem_addr_o=pc+cnt, held stable until mem_ack_i.
    - On ack, store mem_rdata_i into byte cnt (byte0 = inst[7:0]), cnt++.
    - After the 4th ack: write the word to the cache, latch outputs, go READY.
    - Miss latency is 4 ack cycles + 1 LOOKUP cycle.
  - READY:
    - inst_valid_o=1.
    - Transfer occurs on a cycle with inst_valid_o=1 and stall_i=0.
    - On transfer: pc+=4 (mod 2^32 wrap), go LOOKUP, inst_valid_o=0 next cycle.
    - While stall_i=1: outputs held bit-stable for any number of cycles.
- Back-to-back hits therefore deliver one instruction every 2 cycles.
- Redirect (branch_taken_i=1) takes priority over everything except reset:
  - pc=branch_target_i, state=LOOKUP, cnt=0.
  - Partial bytes discarded, no cache write.
  - inst_valid_o is gated combinationally: inst_valid_o = valid_q & ~branch_taken_i, so no wrong-path instruction transfers in the redirect cycle.
  - mem_req_o drops the next cycle. An ack arriving in the redirect cycle is ignored; the controller tolerates request withdrawal.
  - Redirect coincident with the 4th ack: byte dropped, no fill.
- Redirect while stalled: held instruction dropped, new pc fetched.
- mem_req_o is never high outside FETCH. mem_addr_o holds its last value when idle.
- Self-modifying code is not supported: the cache is not snooped by stores.
- Misaligned targets: low 2 bits are used as given, with no trap.

Test Plan:
- Reset:
  - Stimulus: rst low mid-fetch, then release.
  - Required: all outputs 0 while low. First request after release is mem_addr_o=0x0, mem_req_o=1 on the second cycle (LOOKUP, then FETCH).
- Cold miss:
  - Stimulus: pc 0x0, memory returns 13,00,00,00 with acks on consecutive cycles, stall_i=0.
  - Required: inst_o=0x00000013, pc_o=0x0, inst_valid_o high one cycle. Next request addr 0x4.
- Stall hold:
  - Stimulus: instruction 0x00500093 READY, stall_i=1 for 5 cycles.
  - Required: outputs unchanged and no mem_req_o during the stall. pc advances to +4 only on the cycle after stall drops.
- Redirect mid-fetch:
  - Stimulus: after 2 acks at pc 0x10, branch_taken_i with target 0x100.
  - Required: next request addr 0x100. Entry for 0x10 not filled; refetching 0x10 misses.
- Cache hit:
  - Stimulus: jump back to an already-fetched 0x4.
  - Required: inst_valid_o one cycle after LOOKUP with zero memory requests.
  - Stimulus: with IDX_W=5, access 0x4 then 0x84.
  - Required: 0x84 misses and evicts; the later 0x4 misses again.
- Redirect in transfer cycle:
  - Stimulus: READY, stall_i=0, branch_taken_i=1.
  - Required: inst_valid_o=0 that cycle, pc=target, no pc+4.
